ccip_c1_tx_arbiter: RTL

Shares the single CCI-P c1 (write) TX channel between NUM_CLIENTS producers: the ccip_transmitter instances of several NICs plus auxiliary writers such as status and doorbell write-back. It arbitrates round-robin at request granularity and locks the channel for all beats of a multi-line write (eCL_LEN_2/eCL_LEN_4). It honours sRx_c1TxAlmFull and drives sTx_c1 through one register stage.

---
 rtl/ccip_c1_tx_arbiter_pkg.sv | 38 +++
 rtl/ccip_c1_tx_arbiter_if.sv | 25 ++
 rtl/ccip_c1_tx_arbiter_rr_priority_picker.sv | 29 ++
 rtl/ccip_c1_tx_arbiter.sv | 125 ++++++++++++
 4 files changed

// File: rtl/ccip_c1_tx_arbiter_pkg.sv
// Shared CCI-P c1 TX types, arbiter states and line-count helper for the c1 TX arbiter.
package ccip_c1_tx_arbiter_pkg;

  typedef logic [1:0]   t_ccip_clLen;
  typedef logic [511:0] t_ccip_clData;

  localparam t_ccip_clLen eCL_LEN_1 = 2'b00;
  localparam t_ccip_clLen eCL_LEN_2 = 2'b01;
  localparam t_ccip_clLen eCL_LEN_4 = 2'b11;

  typedef struct packed {
    logic [15:0] mdata;
    logic [41:0] address;
    logic [3:0]  req_type;
    t_ccip_clLen cl_len;
    logic        sop;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    logic               valid;
    t_ccip_clData       data;
  } t_if_ccip_c1_Tx;

  localparam logic [0:0] ArbIdle   = 1'b0;
  localparam logic [0:0] ArbLocked = 1'b1;

  // The reserved encoding 2'b10 collapses to a single line.
  function automatic logic [2:0] cl_len_to_beats(input t_ccip_clLen len);
    case (len)
      eCL_LEN_1: return 3'd1;
      eCL_LEN_2: return 3'd2;
      eCL_LEN_4: return 3'd4;
      default:   return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/ccip_c1_tx_arbiter_if.sv
// Client-side beat handshake plus the CCI-P c1 TX channel shared by the arbiter.
interface ccip_c1_tx_arbiter_if
  import ccip_c1_tx_arbiter_pkg::*;
#(
  parameter int NUM_CLIENTS = 4
) ();

  logic               [NUM_CLIENTS-1:0] client_valid;
  t_ccip_c1_ReqMemHdr [NUM_CLIENTS-1:0] client_hdr;
  t_ccip_clData       [NUM_CLIENTS-1:0] client_data;
  logic               [NUM_CLIENTS-1:0] client_ready;
  logic                                 sRx_c1TxAlmFull;
  t_if_ccip_c1_Tx                       sTx_c1;

  modport master (
    output client_valid, client_hdr, client_data, sRx_c1TxAlmFull,
    input  client_ready, sTx_c1
  );

  modport slave (
    input  client_valid, client_hdr, client_data, sRx_c1TxAlmFull,
    output client_ready, sTx_c1
  );

endinterface

// File: rtl/ccip_c1_tx_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first requester at or after start, wrapping modulo N.
module ccip_c1_tx_arbiter_rr_priority_picker #(
  parameter int N  = 4,
  parameter int LN = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [LN-1:0] start,
  output logic [N-1:0]  grant,
  output logic          any_grant
);

  always_comb begin
    int   idx;
    logic found;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(start) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx[LN-1:0]]) begin
        grant[idx[LN-1:0]] = 1'b1;
        found              = 1'b1;
      end
    end
    any_grant = |req;
  end

endmodule

// File: rtl/ccip_c1_tx_arbiter.sv
// Round-robin arbiter sharing the CCI-P c1 TX channel, locked per multi-line request.
module ccip_c1_tx_arbiter
  import ccip_c1_tx_arbiter_pkg::*;
#(
  parameter int NUM_CLIENTS  = 4,
  parameter int LNUM_CLIENTS = $clog2(NUM_CLIENTS)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  ccip_c1_tx_arbiter_if.slave      bus,
  output logic [LNUM_CLIENTS-1:0]  grant_id,
  output logic                     busy,
  output logic [31:0]              stall_cnt,
  output logic                     error
);

  logic [0:0]              state;
  logic [2:0]              beats_left;
  logic [LNUM_CLIENTS-1:0] rr_ptr;

  logic [NUM_CLIENTS-1:0]  sop_vec, eligible, pick_oh, ready;
  logic                    any_elig, xfer, orphan;
  logic [LNUM_CLIENTS-1:0] pick_idx, sel_idx;
  t_ccip_c1_ReqMemHdr      sel_hdr;
  t_ccip_clData            sel_data;
  logic [2:0]              beats_new;
  t_if_ccip_c1_Tx          tx_p1;

  function automatic logic [LNUM_CLIENTS-1:0] next_ptr(input logic [LNUM_CLIENTS-1:0] p);
    if (int'(p) == NUM_CLIENTS - 1) return '0;
    return p + 1'b1;
  endfunction

  always_comb begin
    sop_vec = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) sop_vec[i] = bus.client_hdr[i].sop;
  end

  assign eligible = bus.client_valid & sop_vec;

  ccip_c1_tx_arbiter_rr_priority_picker #(.N(NUM_CLIENTS), .LN(LNUM_CLIENTS)) u_picker (
    .req       (eligible),
    .start     (rr_ptr),
    .grant     (pick_oh),
    .any_grant (any_elig)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_CLIENTS; i++)
      if (pick_oh[i]) pick_idx = LNUM_CLIENTS'(i);
  end

  // Stage p0: combinational grant; almost-full only gates new requests.
  always_comb begin
    ready = '0;
    if (reset_n) begin
      if (state == ArbIdle) begin
        if (any_elig && !bus.sRx_c1TxAlmFull) ready = pick_oh;
      end else begin
        ready[grant_id] = bus.client_valid[grant_id];
      end
    end
  end

  assign bus.client_ready = ready;
  assign xfer      = |(bus.client_valid & ready);
  assign sel_idx   = (state == ArbIdle) ? pick_idx : grant_id;
  assign sel_hdr   = bus.client_hdr[sel_idx];
  assign sel_data  = bus.client_data[sel_idx];
  assign beats_new = cl_len_to_beats(sel_hdr.cl_len);
  assign orphan    = (state == ArbIdle) && (|bus.client_valid) && !any_elig;

  // Stage p1: FSM, beat counter and registered channel output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ArbIdle;
      beats_left <= '0;
      rr_ptr     <= '0;
      grant_id   <= '0;
      tx_p1      <= '0;
      stall_cnt  <= '0;
      error      <= 1'b0;
    end else begin
      tx_p1.valid <= 1'b0;
      if (state == ArbIdle) begin
        if (xfer) begin
          tx_p1.valid <= 1'b1;
          tx_p1.hdr   <= sel_hdr;
          tx_p1.data  <= sel_data;
          if (sel_hdr.cl_len == 2'b10) error <= 1'b1;
          if (beats_new > 3'd1) begin
            state      <= ArbLocked;
            grant_id   <= pick_idx;
            beats_left <= beats_new - 3'd1;
          end else begin
            beats_left <= '0;
            rr_ptr     <= next_ptr(pick_idx);
          end
        end
        if (orphan) error <= 1'b1;
        if (any_elig && bus.sRx_c1TxAlmFull && stall_cnt != '1)
          stall_cnt <= stall_cnt + 32'd1;
      end else if (xfer) begin
        // A sop inside a locked request is swallowed without consuming a line.
        if (sel_hdr.sop) begin
          error <= 1'b1;
        end else begin
          tx_p1.valid <= 1'b1;
          tx_p1.hdr   <= sel_hdr;
          tx_p1.data  <= sel_data;
          beats_left  <= beats_left - 3'd1;
          if (beats_left == 3'd1) begin
            state  <= ArbIdle;
            rr_ptr <= next_ptr(grant_id);
          end
        end
      end
    end
  end

  assign bus.sTx_c1 = tx_p1;
  assign busy       = (state == ArbLocked);

endmodule
